// File: rtl/key_event_scanner.sv
// Debounced key scanner: picks the lowest pressed key, qualifies it, emits its index over
// valid/ready, drives lamp feedback (blink or latching toggle) and waits for a clean release.
module key_event_scanner #(
    parameter int unsigned NUM_KEYS        = 40,
    parameter int unsigned IDX_W           = 6,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
    parameter int unsigned BLINK_CYCLES    = 6_000_000,
    parameter int unsigned BLINK_TOGGLES   = 4,
    parameter int unsigned LAMP_MODE       = 0,
    parameter int unsigned CNT_W           = 26
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_key,
    output logic [NUM_KEYS-1:0] lamp,
    output logic                busy
);

    localparam int unsigned TGL_W = (BLINK_TOGGLES < 2) ? 1 : $clog2(BLINK_TOGGLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [TGL_W-1:0] TGL_LAST =
        TGL_W'((BLINK_TOGGLES == 0) ? 0 : BLINK_TOGGLES - 1);
    localparam logic [NUM_KEYS-1:0] NOT_PRESSED = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_KEYS-1:0] ONE_HOT0    = {{(NUM_KEYS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StEmit,
        StBlink,
        StWaitRel
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [NUM_KEYS-1:0] r_sync1, r_sync2;
    logic [NUM_KEYS-1:0] w_pressed, w_idx_onehot;
    logic [NUM_KEYS-1:0] r_lamp, w_lamp_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt, w_lowest;
    logic [CNT_W-1:0]    r_timer, w_timer_nxt;
    logic [TGL_W-1:0]    r_tgl, w_tgl_nxt;
    logic                w_any, w_cur;

    assign w_pressed    = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_any        = |w_pressed;
    assign w_idx_onehot = ONE_HOT0 << r_idx;
    // Captured key's current level, masked rather than indexed so any IDX_W is legal
    assign w_cur        = |(w_pressed & w_idx_onehot);

    always_comb begin
        w_lowest = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (w_pressed[i]) begin
                w_lowest = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_tgl_nxt   = r_tgl;
        w_lamp_nxt  = r_lamp;
        case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_idx_nxt   = w_lowest;
                    w_timer_nxt = '0;
                    w_state_nxt = StDebounce;
                end
            end
            StDebounce: begin
                if (!w_cur) begin
                    w_state_nxt = StIdle;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nxt = StEmit;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            StEmit: begin
                if (evt_ready) begin
                    w_timer_nxt = '0;
                    w_tgl_nxt   = '0;
                    if (LAMP_MODE != 0) begin
                        w_lamp_nxt  = r_lamp ^ w_idx_onehot;
                        w_state_nxt = StWaitRel;
                    end else if (BLINK_TOGGLES != 0) begin
                        w_state_nxt = StBlink;
                    end else begin
                        w_state_nxt = StWaitRel;
                    end
                end
            end
            StBlink: begin
                if (r_timer == BLK_LAST) begin
                    w_lamp_nxt  = r_lamp ^ w_idx_onehot;
                    w_timer_nxt = '0;
                    w_tgl_nxt   = r_tgl + 1'b1;
                    if (r_tgl == TGL_LAST) begin
                        w_state_nxt = StWaitRel;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            StWaitRel: begin
                // Any bounce back to pressed restarts the release qualification
                if (w_cur) begin
                    w_timer_nxt = '0;
                end else if (r_timer == DEB_LAST) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sync1 <= NOT_PRESSED;
            r_sync2 <= NOT_PRESSED;
            r_idx   <= '0;
            r_timer <= '0;
            r_tgl   <= '0;
            r_lamp  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= keys_in;
            r_sync2 <= r_sync1;
            r_idx   <= w_idx_nxt;
            r_timer <= w_timer_nxt;
            r_tgl   <= w_tgl_nxt;
            r_lamp  <= w_lamp_nxt;
        end
    end

    assign evt_valid = (r_state == StEmit);
    assign evt_key   = r_idx;
    assign lamp      = r_lamp;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_key_event_scanner.sv
// Bench for key_event_scanner: a blink instance and a latching-lamp instance, both checked
// every cycle against a phase-level reference model, plus directed literal expectations.
module tb_key_event_scanner;

    localparam int D = 4;
    localparam int B = 3;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic [1:0] rst_v;
    logic [1:0] rdy_v;
    logic [1:0] v_v;
    logic [1:0] busy_v;
    logic [7:0] keys   [2];
    logic [7:0] lamp_o [2];
    logic [2:0] key_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_scanner #(
        .NUM_KEYS(8), .IDX_W(3), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B),
        .BLINK_TOGGLES(T), .LAMP_MODE(0), .CNT_W(3)
    ) u_dut0 (
        .sys_clk(clk), .rst(rst_v[0]), .keys_in(keys[0]), .evt_valid(v_v[0]),
        .evt_ready(rdy_v[0]), .evt_key(key_o[0]), .lamp(lamp_o[0]), .busy(busy_v[0])
    );

    key_event_scanner #(
        .NUM_KEYS(8), .IDX_W(3), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B),
        .BLINK_TOGGLES(T), .LAMP_MODE(1), .CNT_W(3)
    ) u_dut1 (
        .sys_clk(clk), .rst(rst_v[1]), .keys_in(keys[1]), .evt_valid(v_v[1]),
        .evt_ready(rdy_v[1]), .evt_key(key_o[1]), .lamp(lamp_o[1]), .busy(busy_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. ph: 0 idle, 1 qualifying press, 2 offering event, 3 blinking,
    // 4 qualifying release. ps1/ps2 hold the pressed-high view of the two-stage delay.
    int         ph   [2] = '{0, 0};
    int         midx [2] = '{0, 0};
    int         run  [2] = '{0, 0};
    int         rel  [2] = '{0, 0};
    int         elap [2] = '{0, 0};
    logic [7:0] mlamp[2] = '{8'h00, 8'h00};
    logic [7:0] ps1  [2] = '{8'h00, 8'h00};
    logic [7:0] ps2  [2] = '{8'h00, 8'h00};
    bit         started = 1'b0;

    task automatic model_step(input int u, input logic [7:0] k, input logic rdy,
                              input logic r, input int lm);
        logic [7:0] p;
        p = ps2[u];
        if (r) begin
            ph[u] = 0; midx[u] = 0; run[u] = 0; rel[u] = 0; elap[u] = 0;
            mlamp[u] = 8'h00; ps1[u] = 8'h00; ps2[u] = 8'h00;
        end else begin
            case (ph[u])
                0: if (p != 8'h00) begin
                    for (int i = 7; i >= 0; i--) if (p[i]) midx[u] = i;
                    run[u] = 0;
                    ph[u] = 1;
                end
                1: if (!p[midx[u]]) ph[u] = 0;
                   else begin
                       run[u]++;
                       if (run[u] == D) ph[u] = 2;
                   end
                2: if (rdy) begin
                    if (lm == 1) begin
                        mlamp[u][midx[u]] = ~mlamp[u][midx[u]];
                        rel[u] = 0;
                        ph[u] = 4;
                    end else begin
                        elap[u] = 0;
                        ph[u] = 3;
                    end
                end
                3: begin
                    elap[u]++;
                    if (elap[u] % B == 0) mlamp[u][midx[u]] = ~mlamp[u][midx[u]];
                    if (elap[u] == B * T) begin
                        rel[u] = 0;
                        ph[u] = 4;
                    end
                end
                4: if (p[midx[u]]) rel[u] = 0;
                   else begin
                       rel[u]++;
                       if (rel[u] == D) ph[u] = 0;
                   end
                default: ph[u] = 0;
            endcase
            ps2[u] = ps1[u];
            ps1[u] = ~k;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, keys[0], rdy_v[0], rst_v[0], 0);
        model_step(1, keys[1], rdy_v[1], rst_v[1], 1);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("dut%0d busy", u), 32'(busy_v[u]), 32'(ph[u] != 0));
                chk($sformatf("dut%0d evt_valid", u), 32'(v_v[u]), 32'(ph[u] == 2));
                chk($sformatf("dut%0d lamp", u), 32'(lamp_o[u]), 32'(mlamp[u]));
                if (ph[u] == 2) chk($sformatf("dut%0d evt_key", u), 32'(key_o[u]), midx[u]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int u, input int budget);
        for (int i = 0; i < budget && !v_v[u]; i++) step();
        chk($sformatf("dut%0d wait evt_valid", u), 32'(v_v[u]), 32'd1);
    endtask

    task automatic wait_idle(input int u, input int budget);
        for (int i = 0; i < budget && busy_v[u]; i++) step();
        chk($sformatf("dut%0d wait idle", u), 32'(busy_v[u]), 32'd0);
    endtask

    initial begin
        logic [7:0] k;
        int         hold;
        rst_v = 2'b11; rdy_v = 2'b11;
        keys[0] = 8'hFF; keys[1] = 8'hFF;
        step(); step();
        rst_v = 2'b00;

        // Reset state and idle with all keys released
        chk("reset evt_valid", 32'(v_v[0]), 0);
        chk("reset lamp", 32'(lamp_o[0]), 32'h00);
        chk("reset busy", 32'(busy_v[0]), 0);
        chk("reset evt_key", 32'(key_o[0]), 0);
        repeat (20) begin
            step();
            chk("idle busy", 32'(busy_v[0]), 0);
        end

        // Key 5: latency, blink pattern, release qualification
        keys[0] = 8'hDF;
        repeat (6) step();
        chk("key5 not yet valid", 32'(v_v[0]), 0);
        step();
        chk("key5 valid at 7", 32'(v_v[0]), 1);
        chk("key5 index", 32'(key_o[0]), 5);
        step();
        chk("key5 valid one cycle", 32'(v_v[0]), 0);
        step(); step();
        chk("blink pre", 32'(lamp_o[0]), 32'h00);
        step();
        chk("blink 1", 32'(lamp_o[0]), 32'h20);
        repeat (3) step();
        chk("blink 2", 32'(lamp_o[0]), 32'h00);
        repeat (3) step();
        chk("blink 3", 32'(lamp_o[0]), 32'h20);
        repeat (3) step();
        chk("blink 4", 32'(lamp_o[0]), 32'h00);
        keys[0] = 8'hFF;
        repeat (5) step();
        chk("release busy", 32'(busy_v[0]), 1);
        step();
        chk("release done", 32'(busy_v[0]), 0);

        // Key 2 glitch: two synchronised pressed cycles only
        keys[0] = 8'hFB;
        step(); step();
        keys[0] = 8'hFF;
        repeat (10) begin
            step();
            chk("glitch no event", 32'(v_v[0]), 0);
        end
        chk("glitch idle", 32'(busy_v[0]), 0);
        chk("glitch lamp", 32'(lamp_o[0]), 32'h00);

        // Keys 1 and 3 together, then key 1 released
        keys[0] = 8'hF5;
        wait_valid(0, 30);
        chk("pair first index", 32'(key_o[0]), 1);
        step();
        keys[0] = 8'hF7;
        wait_valid(0, 60);
        chk("pair second index", 32'(key_o[0]), 3);
        step();
        keys[0] = 8'hFF;
        wait_idle(0, 60);

        // Back-pressure on key 6, released while the event is pending
        rdy_v[0] = 1'b0;
        keys[0]  = 8'hBF;
        wait_valid(0, 30);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall valid", 32'(v_v[0]), 1);
            chk("stall index", 32'(key_o[0]), 6);
            if (i == 2) keys[0] = 8'hFF;
        end
        rdy_v[0] = 1'b1;
        step();
        chk("stall handshake", 32'(v_v[0]), 0);
        chk("stall blinking", 32'(busy_v[0]), 1);
        repeat (3) step();
        chk("stall blink lamp", 32'(lamp_o[0]), 32'h40);
        wait_idle(0, 80);
        chk("stall final lamp", 32'(lamp_o[0]), 32'h00);

        // Latching lamp on key 0, then reset mid-debounce
        for (int n = 0; n < 3; n++) begin
            keys[1] = 8'hFE;
            wait_valid(1, 30);
            step();
            chk("latch lamp", 32'(lamp_o[1]), (n % 2 == 0) ? 32'h01 : 32'h00);
            keys[1] = 8'hFF;
            wait_idle(1, 40);
        end
        keys[1] = 8'hFE;
        repeat (4) step();
        chk("latch debouncing", 32'(busy_v[1]), 1);
        keys[1] = 8'hFF;
        rst_v[1] = 1'b1;
        step();
        rst_v[1] = 1'b0;
        chk("rst lamp", 32'(lamp_o[1]), 32'h00);
        chk("rst busy", 32'(busy_v[1]), 0);
        repeat (8) begin
            step();
            chk("rst no event", 32'(v_v[1]), 0);
        end

        // Randomised traffic, back-pressure and occasional reset on both instances
        for (int n = 0; n < 250; n++) begin
            for (int u = 0; u < 2; u++) begin
                k = 8'hFF;
                if ($urandom_range(0, 1) == 1) begin
                    k[$urandom_range(0, 7)] = 1'b0;
                    if ($urandom_range(0, 2) == 0) k[$urandom_range(0, 7)] = 1'b0;
                end
                keys[u] = k;
            end
            hold = $urandom_range(1, 24);
            repeat (hold) begin
                for (int u = 0; u < 2; u++) begin
                    rdy_v[u] = ($urandom_range(0, 3) != 0);
                    rst_v[u] = ($urandom_range(0, 199) == 0);
                end
                step();
            end
            rst_v = 2'b00;
        end
        keys[0] = 8'hFF; keys[1] = 8'hFF;
        rdy_v = 2'b11;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_scanner.md
Name: key_event_scanner

Overview:
Parametrised, debounced key scanner that generalises the team's 40-switch detector to any key count, either input polarity and two lamp modes. It synchronises the raw switch bank and selects the lowest-index pressed key. After debouncing, it emits a key-index event over a valid/ready handshake. It then drives per-key lamp feedback and waits for a debounced release. Downstream consumers are the character/rotor logic for the event and the serial shifter for the lamp vector.

Parameters:
NUM_KEYS, 40, number of key inputs (2..64)
IDX_W, 6, width of key index; must satisfy 2^IDX_W >= NUM_KEYS
ACTIVE_LOW, 1, 1: key pressed when input is 0; 0: pressed when input is 1
DEBOUNCE_CYCLES, 5_000_000, press/release qualification time in cycles (>=1)
BLINK_CYCLES, 6_000_000, cycles between lamp toggles in blink mode (>=1)
BLINK_TOGGLES, 4, number of lamp toggles per event in blink mode (0 = no blink)
LAMP_MODE, 0, 0: blink feedback; 1: latching toggle, lamp inverted once per event
CNT_W, 26, timer width; must hold max(DEBOUNCE_CYCLES, BLINK_CYCLES)

Ports:
sys_clk  in  1  clock
rst  in  1  reset, synchronous, active-high
keys_in  in  NUM_KEYS  raw asynchronous switch inputs
evt_valid  out  1  key event available
evt_ready  in  1  consumer accepts event
evt_key  out  IDX_W  index of debounced key; stable while evt_valid=1
lamp  out  NUM_KEYS  lamp/display vector
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at edge): state=IDLE, timer=0, toggle count=0, evt_valid=0, evt_key=0, lamp=0, busy=0, synchroniser flops cleared to "not pressed". rst overrides everything in any state, including mid-debounce, mid-EMIT and mid-blink; a pending event is discarded.
- Input path: 2-flop synchroniser per key, then polarity normalisation to pressed=1. Call this p[].
- IDLE: if any p[i]=1, capture idx = lowest such i, clear timer, go DEBOUNCE. Otherwise stay.
- DEBOUNCE: if p[idx]=0 on any cycle, go IDLE (glitch reject). Else if timer==DEBOUNCE_CYCLES-1, go EMIT. Else timer++.
- EMIT: evt_valid=1, evt_key=idx. The handshake completes on the edge where evt_valid&evt_ready=1. evt_key must not change while valid. The key may be released during EMIT; the event still completes.
- On handshake:
  - LAMP_MODE=1: lamp[idx] inverted on the same edge, then go WAIT_REL.
  - LAMP_MODE=0 with BLINK_TOGGLES>0: go BLINK with timer=0 and toggle count=0.
  - LAMP_MODE=0 with BLINK_TOGGLES=0: go WAIT_REL.
- BLINK: timer counts. When timer==BLINK_CYCLES-1: lamp[idx] inverts, timer=0, count++. After the BLINK_TOGGLES-th toggle, go WAIT_REL. Even BLINK_TOGGLES leaves lamp[idx] at its pre-event value.
- WAIT_REL: p[idx] must be 0 for DEBOUNCE_CYCLES consecutive cycles, then go IDLE. Any p[idx]=1 restarts the timer.
- Latency: keys_in pressed before edge 1 → evt_valid high after edge 3+DEBOUNCE_CYCLES (2 synchroniser edges, 1 capture edge, DEBOUNCE_CYCLES qualification edges).
- Simultaneous presses: lowest index wins. Other keys are ignored until IDLE. A key still held on return to IDLE is captured afresh and produces a new event.
- Only lamp[idx] is ever modified; all other lamp bits hold.
- Timer never wraps: it is compared and cleared before reaching 2^CNT_W.

Test Plan:
Bench parameters for all scenarios: NUM_KEYS=8, IDX_W=3, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, BLINK_CYCLES=3, BLINK_TOGGLES=4, LAMP_MODE=0, evt_ready tied to 1 unless stated.
1. Reset → evt_valid=0, lamp=8'h00, busy=0. Drive keys_in=8'hFF for 20 cycles → no event, busy stays 0.
2. keys_in=8'hDF (key 5) held:
   - evt_valid rises exactly 7 cycles after the press, for 1 cycle, with evt_key=5.
   - lamp=8'h20, 8'h00, 8'h20, 8'h00 at 3-cycle intervals.
   - busy remains 1 until key 5 has been released for 4 cycles.
3. Key 2 low for 2 synchronised cycles, then released → no evt_valid; return to IDLE; lamp unchanged.
4. keys_in=8'hF5 (keys 1 and 3) pressed together → event with evt_key=1. Release key 1 while key 3 stays held → second event with evt_key=3 after the key 1 release debounce.
5. evt_ready=0 for 10 cycles after evt_valid rises → evt_valid and evt_key=6 held stable. Key 6 released meanwhile. Raise evt_ready → single handshake, then blink.
6. LAMP_MODE=1: press/release key 0 twice → lamp[0]=1 after the first handshake, 0 after the second. Assert rst during the second DEBOUNCE → lamp=0, no event, state IDLE.
